hamming_decoder: RTL and testbench
==================================

// Module: hamming_decoder
// PURPOSE
//  Serial Hamming [7,4] decoder, receive-side partner of hamming_coder on the same 1-bit link.
//  - Collects 7 code bits per codeword, computes the syndrome and corrects any single-bit error.
//  - Re-serialises the 4 data bits, data[0] first, with a valid strobe and error status.
// PARAMETERS
//  CORRECT    1  1: flip the bit at the syndrome position; 0: detect only, pass data uncorrected
//  OUT_MSB    0  0: emit d1..d4 (data[0] first); 1: emit d4..d1
// PORTS
//  clk        in   1  clock, all logic on posedge
//  reset      in   1  synchronous, active-low reset
//  enable     in   1  qualifies in; one code bit is consumed per posedge with enable=1
//  in         in   1  serial code bit
//  out        out  1  serial decoded data bit, meaningful only while out_valid=1
//  out_valid  out  1  high for exactly 4 consecutive cycles per codeword
//  corrected  out  1  syndrome!=0 for the current word; held over its 4 out_valid cycles
//  syndrome   out  3  {s3,s2,s1} = error position 1..7 (0 = clean), held with out_valid
// BEHAVIOUR
//  - Code bit order on the wire is position 1 first: p1 p2 d1 p3 d2 d3 d4 (pos1..pos7).
//  - Reset (reset=0 at posedge): the following are cleared on that edge.
//    - bit counter=0, shift register=0
//    - out=0, out_valid=0, corrected=0, syndrome=0
//    - A partially received word is discarded and any output burst in progress is aborted.
//  - Receive: 3-bit counter cnt runs 0..6 and advances only on enabled edges.
//    - enable=0 holds cnt and the shift register; gaps of any length are allowed.
//    - The edge with enable=1 and cnt=6 completes the word; cnt then wraps to 0.
//  - Decode on the completing edge, combinational from the 6 stored bits plus the live in bit:
//    - s1=c1^c3^c5^c7, s2=c2^c3^c6^c7, s3=c4^c5^c6^c7.
//    - With CORRECT=1 and syndrome!=0, c[syndrome] is inverted before the data bits are extracted.
//    - d1=c3, d2=c5, d3=c6, d4=c7; the result is loaded into a 4-bit output register.
//    - syndrome and corrected are latched on the same edge.
//  - Output FSM: IDLE -> SEND(k=0..3) -> IDLE.
//    - Latency: out_valid rises the cycle after the completing edge.
//    - SEND is free-running; enable does not gate it. One bit per cycle for 4 cycles.
//    - After the 4th bit: out_valid=0, out=0, corrected and syndrome cleared.
//  - Overlap: receive continues during SEND.
//    - The next completion cannot occur within 4 cycles (needs 7 enabled edges), so no collision.
//    - If a completion edge coincides with the last SEND cycle, the new word loads and SEND restarts at k=0 seamlessly.
//  - Double-bit errors are miscorrected to a wrong single-bit fix (inherent to [7,4]); no detection is required.
//  - With CORRECT=0, corrected still reports syndrome!=0.
// TESTING
//  1. Clean word 0011: in=0,1,1,1,1,0,0 with enable=1 -> out=1,1,0,0 on 4 out_valid cycles, corrected=0, syndrome=0.
//  2. Error at pos5: in=0,1,1,1,0,0,0 -> syndrome=5, corrected=1, out=1,1,0,0.
//     With CORRECT=0 the same input -> out=1,0,0,0, corrected=1.
//  3. Sweep single errors: for each data 0..15 and error position 1..7 -> decoded data equals the original and syndrome equals the position.
//  4. Gapped input: the clean word from test 1 with enable=0 for 3 cycles between bits 2 and 3 -> identical output; out_valid one cycle after the 7th enabled bit.
//  5. Back-to-back: words 0011 then 1010 with no gaps -> two 4-cycle bursts 1,1,0,0 and 0,1,0,1 separated by 3 idle cycles.
//  6. Reset mid-word after 4 bits, then the full clean word -> no spurious burst; one correct burst. Reset during SEND -> out_valid drops the next cycle.

Source files
------------

// File: rtl/hamming_decoder.sv
// Serial [7,4] Hamming decoder: collects 7 code bits, fixes a single-bit error, re-serialises 4 data bits.
// Burst starts the cycle after the 7th enabled bit; enable only gates input, output burst is free-running.
module hamming_decoder #(
    parameter bit CORRECT = 1'b1,
    parameter bit OUT_MSB = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       in,
    output logic       out,
    output logic       out_valid,
    output logic       corrected,
    output logic [2:0] syndrome
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [5:0] shreg_q, shreg_d;
    logic [1:0] k_q, k_d;
    logic [3:0] data_q, data_d;
    logic       corrected_q, corrected_d;
    logic [2:0] syndrome_q, syndrome_d;

    logic [6:0] code;
    logic [2:0] syn;
    logic       fix;
    logic [3:0] data_fixed;
    logic       done;
    logic [1:0] idx;

    // code[i] holds wire position i+1; the live bit is position 7
    always_comb begin
        code   = {in, shreg_q};
        syn[0] = code[0] ^ code[2] ^ code[4] ^ code[6];
        syn[1] = code[1] ^ code[2] ^ code[5] ^ code[6];
        syn[2] = code[3] ^ code[4] ^ code[5] ^ code[6];
        fix    = CORRECT && (syn != 3'd0);
        data_fixed[0] = code[2] ^ (fix && (syn == 3'd3));
        data_fixed[1] = code[4] ^ (fix && (syn == 3'd5));
        data_fixed[2] = code[5] ^ (fix && (syn == 3'd6));
        data_fixed[3] = code[6] ^ (fix && (syn == 3'd7));
    end

    assign done = enable && (cnt_q == 3'd6);

    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (enable) begin
            shreg_d = {in, shreg_q[5:1]};
            cnt_d   = done ? 3'd0 : cnt_q + 3'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        data_d      = data_q;
        corrected_d = corrected_q;
        syndrome_d  = syndrome_q;
        case (state_q)
            IDLE: ;
            SEND: begin
                if (k_q == 2'd3) begin
                    state_d     = IDLE;
                    k_d         = 2'd0;
                    data_d      = 4'd0;
                    corrected_d = 1'b0;
                    syndrome_d  = 3'd0;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // a completing word always (re)starts the burst, including on the last SEND cycle
        if (done) begin
            state_d     = SEND;
            k_d         = 2'd0;
            data_d      = data_fixed;
            corrected_d = (syn != 3'd0);
            syndrome_d  = syn;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            shreg_q     <= 6'd0;
            k_q         <= 2'd0;
            data_q      <= 4'd0;
            corrected_q <= 1'b0;
            syndrome_q  <= 3'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            k_q         <= k_d;
            data_q      <= data_d;
            corrected_q <= corrected_d;
            syndrome_q  <= syndrome_d;
        end
    end

    assign idx       = OUT_MSB ? (2'd3 - k_q) : k_q;
    assign out_valid = (state_q == SEND);
    assign out       = out_valid ? data_q[idx] : 1'b0;
    assign corrected = corrected_q;
    assign syndrome  = syndrome_q;

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder: default, detect-only and MSB-first instances share one stimulus.
module tb_hamming_decoder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic in = 1'b0;

    logic out, out_valid, corrected;
    logic [2:0] syndrome;
    logic out_nc, ov_nc, corr_nc;
    logic [2:0] syn_nc;
    logic out_m, ov_m, corr_m;
    logic [2:0] syn_m;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_cyc = 0;

    logic       qd[$], qc[$], qd_nc[$], qc_nc[$], qd_m[$];
    logic [2:0] qs[$];
    int         qt[$];

    localparam logic [6:0] CLEAN_0011 = 7'b0011110;
    localparam logic [6:0] ERR5_0011  = 7'b0001110;
    localparam logic [6:0] CLEAN_1010 = 7'b1010010;

    hamming_decoder #(.CORRECT(1'b1), .OUT_MSB(1'b0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .in(in),
        .out(out), .out_valid(out_valid), .corrected(corrected), .syndrome(syndrome));

    hamming_decoder #(.CORRECT(1'b0), .OUT_MSB(1'b0)) dut_nc (
        .clk(clk), .reset(reset), .enable(enable), .in(in),
        .out(out_nc), .out_valid(ov_nc), .corrected(corr_nc), .syndrome(syn_nc));

    hamming_decoder #(.CORRECT(1'b1), .OUT_MSB(1'b1)) dut_m (
        .clk(clk), .reset(reset), .enable(enable), .in(in),
        .out(out_m), .out_valid(ov_m), .corrected(corr_m), .syndrome(syn_m));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            qd.push_back(out);
            qc.push_back(corrected);
            qs.push_back(syndrome);
            qt.push_back(cyc);
        end
        if (ov_nc) begin
            qd_nc.push_back(out_nc);
            qc_nc.push_back(corr_nc);
        end
        if (ov_m) qd_m.push_back(out_m);
    end

    function automatic logic [6:0] enc(input logic [3:0] d);
        enc = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic b);
        @(negedge clk);
        enable = en;
        in     = b;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [6:0] c, input int gap);
        for (int i = 0; i < 7; i++) begin
            if (i == 2) idle(gap);
            drive(1'b1, c[i]);
        end
        last_cyc = cyc;
    endtask

    task automatic take_word(input string tag, output logic [3:0] d, output logic [3:0] dn,
                             output logic [3:0] dm, output logic [2:0] s, output logic c,
                             output logic cn, output int t0);
        d = 'x; dn = 'x; dm = 'x; s = 'x; c = 1'bx; cn = 1'bx; t0 = -1;
        chk({tag, "_burst_len"}, (qd.size() >= 4) && (qd_nc.size() >= 4) && (qd_m.size() >= 4), 1);
        if (qd.size() < 4 || qd_nc.size() < 4 || qd_m.size() < 4) return;
        s  = qs[0];
        c  = qc[0];
        cn = qc_nc[0];
        t0 = qt[0];
        chk({tag, "_consecutive"}, qt[3] - qt[0], 3);
        for (int k = 0; k < 4; k++) begin
            d[k]  = qd.pop_front();
            dn[k] = qd_nc.pop_front();
            dm[k] = qd_m.pop_front();
            void'(qc.pop_front());
            void'(qs.pop_front());
            void'(qt.pop_front());
            void'(qc_nc.pop_front());
        end
    endtask

    initial begin
        logic [3:0] d, dn, dm, d2, dn2, dm2;
        logic [2:0] s, s2;
        logic c, cn, c2, cn2;
        int t0, t1, tdone, tdone2;

        idle(2);
        reset = 1'b1;
        chk("rst_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_corr", corrected, 0);
        chk("rst_syn", syndrome, 0);
        chk("rst_nc", {ov_nc, out_nc, corr_nc, syn_nc}, 0);
        chk("rst_msb", {ov_m, out_m, corr_m, syn_m}, 0);

        // clean word 0011
        send_word(CLEAN_0011, 0);
        tdone = last_cyc;
        idle(6);
        take_word("clean", d, dn, dm, s, c, cn, t0);
        chk("clean_data", d, 4'b0011);
        chk("clean_syn", s, 0);
        chk("clean_corr", c, 0);
        chk("clean_latency", t0, tdone + 1);
        chk("clean_nc_data", dn, 4'b0011);
        chk("clean_nc_corr", cn, 0);
        chk("clean_msb_stream", dm, 4'b1100);

        // single error at position 5
        send_word(ERR5_0011, 0);
        idle(6);
        take_word("err5", d, dn, dm, s, c, cn, t0);
        chk("err5_data", d, 4'b0011);
        chk("err5_syn", s, 5);
        chk("err5_corr", c, 1);
        chk("err5_nc_data", dn, 4'b0001);
        chk("err5_nc_corr", cn, 1);

        // every data value with every single-bit error position
        for (int v = 0; v < 16; v++) begin
            for (int p = 1; p <= 7; p++) begin
                send_word(enc(4'(v)) ^ (7'd1 << (p - 1)), 0);
                idle(6);
                take_word("sweep", d, dn, dm, s, c, cn, t0);
                chk($sformatf("sweep_data_v%0d_p%0d", v, p), d, v);
                chk($sformatf("sweep_syn_v%0d_p%0d", v, p), s, p);
            end
        end

        // gap of 3 disabled cycles between bits 2 and 3
        send_word(CLEAN_0011, 3);
        tdone = last_cyc;
        idle(6);
        take_word("gap", d, dn, dm, s, c, cn, t0);
        chk("gap_data", d, 4'b0011);
        chk("gap_latency", t0, tdone + 1);

        // back-to-back words
        send_word(CLEAN_0011, 0);
        send_word(CLEAN_1010, 0);
        tdone2 = last_cyc;
        idle(6);
        take_word("b2b_a", d, dn, dm, s, c, cn, t0);
        take_word("b2b_b", d2, dn2, dm2, s2, c2, cn2, t1);
        chk("b2b_a_data", d, 4'b0011);
        chk("b2b_b_data", d2, 4'b1010);
        chk("b2b_b_msb_stream", dm2, 4'b0101);
        chk("b2b_spacing", t1 - t0, 7);
        chk("b2b_b_latency", t1, tdone2 + 1);

        // reset after 4 bits discards the partial word
        for (int i = 0; i < 4; i++) drive(1'b1, CLEAN_0011[i]);
        drive(1'b0, 1'b0);
        reset = 1'b0;
        drive(1'b0, 1'b0);
        reset = 1'b1;
        chk("midrst_no_burst", qd.size(), 0);
        send_word(CLEAN_0011, 0);
        idle(6);
        chk("midrst_one_burst", qd.size(), 4);
        take_word("midrst", d, dn, dm, s, c, cn, t0);
        chk("midrst_data", d, 4'b0011);

        // reset during SEND aborts the burst
        send_word(ERR5_0011, 0);
        drive(1'b0, 1'b0);
        chk("sendrst_pre_valid", out_valid, 1);
        chk("sendrst_pre_corr", corrected, 1);
        reset = 1'b0;
        drive(1'b0, 1'b0);
        reset = 1'b1;
        chk("sendrst_valid", out_valid, 0);
        chk("sendrst_out", out, 0);
        chk("sendrst_corr", corrected, 0);
        chk("sendrst_syn", syndrome, 0);
        idle(6);
        chk("sendrst_samples", qd.size(), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
